dev_pwr_sink: RTL and testbench
===============================

DEV_PWR_SINK -- requirements
Module: dev_pwr_sink

Interface
REQ-001 Parameter IDLE_TIMEOUT, default 64, is the number of AWAKE cycles without a device-5 write before auto-sleep (range 2..1023).
REQ-002 Parameter WAKE_LAT, default 4, is the number of WAKING cycles before the device is awake (range 1..15).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid_i  input  1  request valid from the buffering stage.
REQ-006 req_addr_i  input  19  bits [2:0] are the device id; bits [18:3] are the register address.
REQ-007 req_data_i  input  16  write data.
REQ-008 req_ready_o  output  1  request accepted when high together with req_valid_i.
REQ-009 opmode_o  output  1  1 = device 5 awake; drives the buffering stage's dev_opmode_i.
REQ-010 sleep_req_i  input  1  single-cycle pulse requesting device 5 to sleep.
REQ-011 wake_i  input  1  single-cycle pulse requesting device 5 to wake.
REQ-012 wr_en_o, wr_dev_o[2:0], wr_addr_o[15:0], wr_data_o[15:0]  outputs  registered register-file write port.
REQ-013 stall_cnt_o  output  8  saturating count of cycles in which a device-5 request was held off.

Function
REQ-014 Transfer occurs on req_valid_i & req_ready_o.
REQ-015 req_ready_o is 1 except when req_addr_i[2:0]==5 and the state is not AWAKE; it is combinational from the state and the address only, never from req_valid_i.
REQ-016 A transfer in cycle N drives wr_en_o=1 in cycle N+1 with the captured device, address and data; otherwise wr_en_o=0 and the write fields hold their last value.
REQ-017 The power FSM states are SLEEP, WAKING and AWAKE; opmode_o is 1 only in AWAKE and is registered.
REQ-018 SLEEP: on wake_i, go to WAKING and load the timer with WAKE_LAT-1.
REQ-019 WAKING: decrement the timer each cycle; at 0, go to AWAKE and load the timer with IDLE_TIMEOUT-1.
REQ-020 WAKING: sleep_req_i and wake_i are ignored.
REQ-021 AWAKE: a device-5 transfer reloads the timer with IDLE_TIMEOUT-1; otherwise the timer decrements; at 0, go to SLEEP.
REQ-022 AWAKE: sleep_req_i goes to SLEEP next cycle unless a device-5 transfer occurs in the same cycle, in which case the request is dropped and the transfer wins.
REQ-023 sleep_req_i and wake_i asserted in the same cycle are both ignored in every state.
REQ-024 wake_i while already AWAKE reloads the idle timer and causes no state change.
REQ-025 Transfers to devices other than 5 are accepted in every state and never affect the timer or the FSM.
REQ-026 stall_cnt_o increments on each cycle with req_valid_i=1, addr[2:0]=5 and req_ready_o=0, and saturates at 255.

Reset
REQ-027 When reset_n is low, the block asynchronously goes to SLEEP with opmode_o=0, wr_en_o=0, wr_dev_o/wr_addr_o/wr_data_o=0, stall_cnt_o=0 and the timer at 0.
REQ-028 Reset mid-WAKING or mid-write discards the operation; no wr_en_o pulse occurs after reset_n deasserts.
REQ-029 In the first cycle after reset_n deasserts, req_ready_o follows REQ-015 with state SLEEP.

Structure
REQ-030 Package dev_pwr_pkg holds the power-state enum, DEV_ID_SLEEPY=3'h5, and the address field widths.
REQ-031 The down-counter with load, decrement and zero flag is sub-module pwr_timer (10-bit) and is instantiated once.

Verification
REQ-032 Reset, then drive wake_i at cycle 0 -> opmode_o=1 at cycle 1+WAKE_LAT (cycle 5 with defaults); req_ready_o for device 5 is 0 until then.
REQ-033 AWAKE, send addr=19'h0AAA5, data=16'h1234 -> wr_en_o=1 next cycle with wr_dev_o=5, wr_addr_o=16'h1554, wr_data_o=16'h1234.
REQ-034 AWAKE with no device-5 traffic -> SLEEP exactly 64 cycles after the last device-5 transfer; a device-5 transfer at cycle 63 postpones the sleep by another 64 cycles.
REQ-035 AWAKE, sleep_req_i in the same cycle as a device-5 transfer -> opmode_o stays 1 and the write is issued.
REQ-036 SLEEP, device-5 valid held for 300 cycles, device-3 writes interleaved -> device-3 writes all complete and stall_cnt_o saturates at 255.
REQ-037 Assert reset_n low in the 2nd WAKING cycle -> SLEEP with opmode_o=0 and all outputs at their reset values.

Source files
------------

// File: rtl/dev_pwr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dev_pwr_pkg
// Description : Shared types and constants for the device-5 power sink:
//               power-state encoding, the sleepy device id and field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package dev_pwr_pkg;

    typedef enum logic [1:0] {
        PWR_SLEEP  = 2'd0,
        PWR_WAKING = 2'd1,
        PWR_AWAKE  = 2'd2
    } pwr_state_e;

    localparam logic [2:0] DEV_ID_SLEEPY = 3'h5;

    localparam int DEV_ID_W   = 3;
    localparam int REG_ADDR_W = 16;
    localparam int REQ_ADDR_W = DEV_ID_W + REG_ADDR_W;
    localparam int DATA_W     = 16;
    localparam int TIMER_W    = 10;

endpackage
`default_nettype wire

// File: rtl/pwr_timer.sv
`default_nettype none
// ============================================================================
// Module      : pwr_timer
// Description : Down-counter with synchronous load, decrement that stops at
//               zero, and a zero flag. Times both wake latency and idle sleep.
// Revision    : 1.0 - initial release
// ============================================================================
module pwr_timer
    import dev_pwr_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] count_q;

    // Load has priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/dev_pwr_sink.sv
`default_nettype none
// ============================================================================
// Module      : dev_pwr_sink
// Description : Request sink feeding a register-file write port. Device 5 is
//               power-managed (SLEEP/WAKING/AWAKE); its requests are held off
//               while not awake and counted as stalls. Other devices always
//               pass straight through.
// Revision    : 1.0 - initial release
// ============================================================================
module dev_pwr_sink
    import dev_pwr_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 64,
    parameter int WAKE_LAT     = 4
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid_i,
    input  logic [REQ_ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0]     req_data_i,
    output logic                  req_ready_o,
    output logic                  opmode_o,
    input  logic                  sleep_req_i,
    input  logic                  wake_i,
    output logic                  wr_en_o,
    output logic [DEV_ID_W-1:0]   wr_dev_o,
    output logic [REG_ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0]     wr_data_o,
    output logic [7:0]            stall_cnt_o
);

    localparam logic [TIMER_W-1:0] WAKE_RELOAD = TIMER_W'(WAKE_LAT - 1);
    localparam logic [TIMER_W-1:0] IDLE_RELOAD = TIMER_W'(IDLE_TIMEOUT - 1);

    pwr_state_e             state_q;
    logic                   opmode_q;
    logic                   wr_en_q;
    logic [DEV_ID_W-1:0]    wr_dev_q;
    logic [REG_ADDR_W-1:0]  wr_addr_q;
    logic [DATA_W-1:0]      wr_data_q;
    logic [7:0]             stall_cnt_q;

    logic                   req_sleepy;
    logic                   xfer;
    logic                   xfer_sleepy;
    logic                   sleep_cmd;
    logic                   wake_cmd;
    logic                   tmr_load;
    logic [TIMER_W-1:0]     tmr_load_val;
    logic                   tmr_dec;
    logic                   tmr_zero;

    // Simultaneous sleep and wake cancel each other in every state.
    assign sleep_cmd   = sleep_req_i & ~wake_i;
    assign wake_cmd    = wake_i & ~sleep_req_i;

    // Ready depends only on state and address so the upstream stage can
    // present a request without a combinational loop through valid.
    assign req_sleepy  = (req_addr_i[DEV_ID_W-1:0] == DEV_ID_SLEEPY);
    assign req_ready_o = ~req_sleepy | (state_q == PWR_AWAKE);
    assign xfer        = req_valid_i & req_ready_o;
    assign xfer_sleepy = xfer & req_sleepy;

    // Timer control: wake latency while WAKING, idle countdown while AWAKE.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        case (state_q)
            PWR_SLEEP: begin
                if (wake_cmd) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = WAKE_RELOAD;
                end
            end
            PWR_WAKING: begin
                if (tmr_zero) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = IDLE_RELOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            PWR_AWAKE: begin
                if (xfer_sleepy || wake_cmd) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = IDLE_RELOAD;
                end else if (sleep_cmd) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = '0;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                tmr_load     = 1'b1;
                tmr_load_val = '0;
            end
        endcase
    end

    pwr_timer u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Power FSM; opmode is registered alongside the state it reflects.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= PWR_SLEEP;
            opmode_q <= 1'b0;
        end else begin
            case (state_q)
                PWR_SLEEP: begin
                    if (wake_cmd) begin
                        state_q <= PWR_WAKING;
                    end
                end
                PWR_WAKING: begin
                    if (tmr_zero) begin
                        state_q  <= PWR_AWAKE;
                        opmode_q <= 1'b1;
                    end
                end
                PWR_AWAKE: begin
                    // A device-5 transfer or a wake keeps the device up and
                    // overrides both an explicit sleep and the idle timeout.
                    if (!(xfer_sleepy || wake_cmd) && (sleep_cmd || tmr_zero)) begin
                        state_q  <= PWR_SLEEP;
                        opmode_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= PWR_SLEEP;
                    opmode_q <= 1'b0;
                end
            endcase
        end
    end

    // Registered write port: one-cycle pulse per transfer, fields hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q   <= 1'b0;
            wr_dev_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= xfer;
            if (xfer) begin
                wr_dev_q  <= req_addr_i[DEV_ID_W-1:0];
                wr_addr_q <= req_addr_i[REQ_ADDR_W-1:DEV_ID_W];
                wr_data_q <= req_data_i;
            end
        end
    end

    // Saturating count of cycles a valid device-5 request was held off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (req_valid_i && req_sleepy && !req_ready_o && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_q <= stall_cnt_q + 8'd1;
        end
    end

    assign opmode_o    = opmode_q;
    assign wr_en_o     = wr_en_q;
    assign wr_dev_o    = wr_dev_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dev_pwr_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_dev_pwr_sink
// Description : Self-checking bench for dev_pwr_sink: wake-up latency, a
//               table of single-cycle vectors, idle timeout with postponement,
//               stall saturation and reset during WAKING.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dev_pwr_sink;

    logic        clk;
    logic        reset_n;
    logic        req_valid_i;
    logic [18:0] req_addr_i;
    logic [15:0] req_data_i;
    logic        req_ready_o;
    logic        opmode_o;
    logic        sleep_req_i;
    logic        wake_i;
    logic        wr_en_o;
    logic [2:0]  wr_dev_o;
    logic [15:0] wr_addr_o;
    logic [15:0] wr_data_o;
    logic [7:0]  stall_cnt_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [18:0] addr;
        logic [15:0] data;
        logic        slp;
        logic        wk;
        logic        e_ready;
        logic        e_wr_en;
        logic [2:0]  e_dev;
        logic [15:0] e_addr;
        logic [15:0] e_data;
        logic        e_op;
        logic [7:0]  e_stall;
    } vec_t;

    vec_t vecs [16];

    dev_pwr_sink #(
        .IDLE_TIMEOUT (64),
        .WAKE_LAT     (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .opmode_o    (opmode_o),
        .sleep_req_i (sleep_req_i),
        .wake_i      (wake_i),
        .wr_en_o     (wr_en_o),
        .wr_dev_o    (wr_dev_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [18:0] a, input logic [15:0] d,
                         input logic s, input logic w);
        req_valid_i = v;
        req_addr_i  = a;
        req_data_i  = d;
        sleep_req_i = s;
        wake_i      = w;
    endtask

    initial begin
        int          pulses;
        int          exp_stall;
        logic        is3;
        logic [15:0] tag;

        vecs[0]  = '{1'b1, 19'h0AAA5,          16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 16'h1554, 16'h1234, 1'b1, 8'd0};
        vecs[1]  = '{1'b0, 19'h00000,          16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 16'h1554, 16'h1234, 1'b1, 8'd0};
        vecs[2]  = '{1'b1, {16'h00FF, 3'd3},   16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 16'h00FF, 16'hBEEF, 1'b1, 8'd0};
        vecs[3]  = '{1'b1, {16'h0010, 3'd5},   16'h5555, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 16'h0010, 16'h5555, 1'b1, 8'd0};
        vecs[4]  = '{1'b0, {16'h0000, 3'd5},   16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 16'h0010, 16'h5555, 1'b1, 8'd0};
        vecs[5]  = '{1'b0, {16'h0000, 3'd3},   16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0010, 16'h5555, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, {16'h0000, 3'd5},   16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 16'h0010, 16'h5555, 1'b0, 8'd0};
        vecs[7]  = '{1'b1, {16'h0123, 3'd5},   16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 16'h0010, 16'h5555, 1'b0, 8'd1};
        vecs[8]  = '{1'b1, {16'hFFFF, 3'd4},   16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 16'hFFFF, 16'h0001, 1'b0, 8'd1};
        vecs[9]  = '{1'b0, {16'h0000, 3'd0},   16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 16'hFFFF, 16'h0001, 1'b0, 8'd1};
        vecs[10] = '{1'b0, {16'h0000, 3'd0},   16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 16'hFFFF, 16'h0001, 1'b0, 8'd1};
        vecs[11] = '{1'b1, {16'h0000, 3'd5},   16'h7777, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 16'hFFFF, 16'h0001, 1'b0, 8'd2};
        vecs[12] = '{1'b0, {16'h0000, 3'd5},   16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 16'hFFFF, 16'h0001, 1'b0, 8'd2};
        vecs[13] = '{1'b1, {16'h0042, 3'd6},   16'h6666, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 16'h0042, 16'h6666, 1'b0, 8'd2};
        vecs[14] = '{1'b0, {16'h0000, 3'd5},   16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 16'h0042, 16'h6666, 1'b1, 8'd2};
        vecs[15] = '{1'b1, {16'hCAFE, 3'd5},   16'hF00D, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 16'hCAFE, 16'hF00D, 1'b1, 8'd2};

        // Reset state
        reset_n = 1'b0;
        drive(1'b0, {16'h0000, 3'd5}, 16'h0000, 1'b0, 1'b0);
        #2;
        chk("rst.opmode",  32'(opmode_o),    32'd0);
        chk("rst.wr_en",   32'(wr_en_o),     32'd0);
        chk("rst.wr_dev",  32'(wr_dev_o),    32'd0);
        chk("rst.wr_addr", 32'(wr_addr_o),   32'd0);
        chk("rst.wr_data", 32'(wr_data_o),   32'd0);
        chk("rst.stall",   32'(stall_cnt_o), 32'd0);
        chk("rst.ready5",  32'(req_ready_o), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Wake-up latency: wake at cycle 0, awake at cycle 5
        drive(1'b0, {16'h0000, 3'd5}, 16'h0000, 1'b0, 1'b1);
        #1;
        chk("wake.c0.ready5", 32'(req_ready_o), 32'd0);
        tick();
        drive(1'b0, {16'h0000, 3'd5}, 16'h0000, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("wake.c%0d.opmode", c), 32'(opmode_o),    32'd0);
            chk($sformatf("wake.c%0d.ready5", c), 32'(req_ready_o), 32'd0);
            tick();
        end
        chk("wake.c5.opmode", 32'(opmode_o),    32'd1);
        chk("wake.c5.ready5", 32'(req_ready_o), 32'd1);

        // Table-driven single-cycle vectors
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].slp, vecs[i].wk);
            #1;
            chk($sformatf("v%0d.ready", i), 32'(req_ready_o), 32'(vecs[i].e_ready));
            tick();
            chk($sformatf("v%0d.wr_en", i),   32'(wr_en_o),     32'(vecs[i].e_wr_en));
            chk($sformatf("v%0d.wr_dev", i),  32'(wr_dev_o),    32'(vecs[i].e_dev));
            chk($sformatf("v%0d.wr_addr", i), 32'(wr_addr_o),   32'(vecs[i].e_addr));
            chk($sformatf("v%0d.wr_data", i), 32'(wr_data_o),   32'(vecs[i].e_data));
            chk($sformatf("v%0d.opmode", i),  32'(opmode_o),    32'(vecs[i].e_op));
            chk($sformatf("v%0d.stall", i),   32'(stall_cnt_o), 32'(vecs[i].e_stall));
        end

        // Idle timeout: last vector was a device-5 transfer at cycle N;
        // a second transfer at N+63 postpones sleep by another 64 cycles.
        drive(1'b0, 19'h0, 16'h0000, 1'b0, 1'b0);
        for (int i = 2; i <= 63; i++) begin
            tick();
            chk($sformatf("to1.c%0d.opmode", i), 32'(opmode_o), 32'd1);
        end
        drive(1'b1, {16'h0063, 3'd5}, 16'h0063, 1'b0, 1'b0);
        #1;
        chk("to.c63.ready5", 32'(req_ready_o), 32'd1);
        tick();
        chk("to.c63.wr_en", 32'(wr_en_o), 32'd1);
        drive(1'b0, {16'h0000, 3'd5}, 16'h0000, 1'b0, 1'b0);
        for (int i = 2; i <= 64; i++) begin
            tick();
            chk($sformatf("to2.c%0d.opmode", i), 32'(opmode_o), 32'd1);
        end
        tick();
        chk("to2.c65.opmode", 32'(opmode_o),    32'd0);
        chk("to2.c65.ready5", 32'(req_ready_o), 32'd0);

        // SLEEP: device-5 valid held 300 cycles with device-3 writes mixed in
        exp_stall = 2;
        pulses    = 0;
        for (int i = 0; i < 300; i++) begin
            is3 = ((i % 10) == 0);
            tag = 16'(i);
            drive(1'b1, {tag, (is3 ? 3'd3 : 3'd5)}, tag, 1'b0, 1'b0);
            #1;
            chk($sformatf("st%0d.ready", i), 32'(req_ready_o), 32'(is3));
            tick();
            if (!is3 && exp_stall < 255) exp_stall++;
            chk($sformatf("st%0d.wr_en", i), 32'(wr_en_o), 32'(is3));
            if (wr_en_o) begin
                pulses++;
                chk($sformatf("st%0d.wr_dev", i),  32'(wr_dev_o),  32'd3);
                chk($sformatf("st%0d.wr_addr", i), 32'(wr_addr_o), 32'(tag));
                chk($sformatf("st%0d.wr_data", i), 32'(wr_data_o), 32'(tag));
            end
            chk($sformatf("st%0d.stall", i), 32'(stall_cnt_o), 32'(exp_stall));
        end
        chk("st.dev3_pulses", 32'(pulses),      32'd30);
        chk("st.stall_sat",   32'(stall_cnt_o), 32'd255);
        chk("st.opmode",      32'(opmode_o),    32'd0);

        // Reset asserted in the second WAKING cycle during a write
        drive(1'b1, {16'h0BAD, 3'd2}, 16'hD00D, 1'b0, 1'b1);
        tick();
        chk("rw.w1.wr_en", 32'(wr_en_o), 32'd1);
        drive(1'b0, 19'h0, 16'h0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, {16'h0777, 3'd1}, 16'h1111, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rw.opmode",  32'(opmode_o),    32'd0);
        chk("rw.wr_en",   32'(wr_en_o),     32'd0);
        chk("rw.wr_dev",  32'(wr_dev_o),    32'd0);
        chk("rw.wr_addr", 32'(wr_addr_o),   32'd0);
        chk("rw.wr_data", 32'(wr_data_o),   32'd0);
        chk("rw.stall",   32'(stall_cnt_o), 32'd0);
        drive(1'b0, {16'h0000, 3'd5}, 16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("rw.post.ready5", 32'(req_ready_o), 32'd0);
        chk("rw.post.wr_en",  32'(wr_en_o),     32'd0);
        drive(1'b0, {16'h0000, 3'd3}, 16'h0000, 1'b0, 1'b0);
        #1;
        chk("rw.post.ready3", 32'(req_ready_o), 32'd1);
        drive(1'b0, {16'h0000, 3'd5}, 16'h0000, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("rw.p%0d.wr_en", i),  32'(wr_en_o),     32'd0);
            chk($sformatf("rw.p%0d.opmode", i), 32'(opmode_o),    32'd0);
            chk($sformatf("rw.p%0d.ready5", i), 32'(req_ready_o), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
